cond_flag_unit: RTL and testbench
=================================

Name: cond_flag_unit

Overview:
- Conditional-execution stage directly downstream of the ALU flag generators (negative, zero, carry, overflow).
- Holds the architectural NZCV register and evaluates the 4-bit ARM condition field of each instruction against the registered flags.
- Gates the instruction's write/branch controls and updates NZCV only for instructions that actually execute.
- Includes a one-entry shadow copy of NZCV for save/restore around exception entry/return.

Parameters:
- NUM_FLAGS, 4, width of flag vector (order N,Z,C,V, MSB = N); fixed at 4, kept for package consistency.
- RESET_FLAGS, 4'b0000, value loaded into NZCV and the shadow register on reset.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- valid_in  input  1  instruction in this stage is valid
- cond  input  4  ARM condition field Instr[31:28]
- flag_write  input  2  [1]=update N,Z; [0]=update C,V (S-bit already decoded)
- alu_n  input  1  negative flag from ALU
- alu_z  input  1  zero flag from ALU
- alu_c  input  1  carry flag from ALU
- alu_v  input  1  overflow flag from ALU flag module
- pc_src_in  input  1  branch/PC-write request from decoder
- reg_write_in  input  1  register-file write request from decoder
- mem_write_in  input  1  memory write request from decoder
- save_flags  input  1  copy NZCV into shadow register
- restore_flags  input  1  copy shadow register into NZCV
- cond_ex  output  1  instruction executes
- pc_src  output  1  pc_src_in & cond_ex
- reg_write  output  1  reg_write_in & cond_ex
- mem_write  output  1  mem_write_in & cond_ex
- nzcv  output  4  registered architectural flags
- shadow_nzcv  output  4  registered shadow flags

Behaviour:
- Reset (rst_n low, asynchronous): nzcv = shadow_nzcv = RESET_FLAGS. Combinational outputs follow their inputs; cond_ex depends on the registered nzcv.
- Condition evaluation is combinational and uses registered nzcv only; zero latency from cond to cond_ex.
- cond_ex = valid_in & condition true. The condition is true as follows:
  - EQ Z; NE !Z
  - CS C; CC !C
  - MI N; PL !N
  - VS V; VC !V
  - HI C&!Z; LS !C|Z
  - GE N==V; LT N!=V
  - GT !Z&(N==V); LE Z|(N!=V)
  - AL 1; 4'b1111 is reserved and evaluates false.
- valid_in=0 forces cond_ex=0, which zeroes pc_src, reg_write and mem_write.
- Flag update at the rising edge when cond_ex=1:
  - flag_write[1] loads N,Z from alu_n, alu_z.
  - flag_write[0] loads C,V from alu_c, alu_v.
  - The two halves are independent. Flags written by instruction k are visible to instruction k+1 one cycle later.
- save_flags=1 at an edge: shadow_nzcv <= nzcv, sampling the pre-edge value even if the same edge also writes nzcv.
- restore_flags=1 at an edge: nzcv <= shadow_nzcv. Restore has priority over any ALU flag write in the same cycle.
- save_flags and restore_flags both high in the same cycle: both occur (the registers swap). This combination is legal.
- Reset asserted mid-operation discards any pending update; no state survives reset.
- No X propagation: an unknown cond outside the table cannot occur because all 16 codes are covered.

Optional Feature:
- Macro: COND_FLAG_FORWARD_EN.
- Defined: adds input fwd_valid (1 bit) and input fwd_nzcv (4 bits).
  - When fwd_valid=1, condition evaluation uses fwd_nzcv instead of nzcv. This lets a back-to-back dependent instruction resolve in the same cycle the producer's flags are being written.
  - Registered state is unaffected.
- Undefined: those ports do not exist; evaluation always uses registered nzcv, and the pipeline must stall one cycle on flag dependency.

Decomposition:
- Package arm_cond_pkg:
  - cond_e enum with the 16 codes: EQ=0 … AL=14, NV=15.
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - typedef nzcv_t as logic [3:0].
- Sub-module cond_check: purely combinational, inputs cond_e and nzcv_t, output cond_true. Reusable by the branch predictor check.
- Top-level cond_flag_unit contains the NZCV register, the shadow register, priority logic and output gating.

Test Plan:
- Reset: rst_n=0 with random inputs -> nzcv=0000 and shadow_nzcv=0000; cond=EQ with valid_in=1 gives cond_ex=0; cond=AL gives cond_ex=1.
- CMP sets flags, then BEQ:
  - Cycle 1: valid_in=1, cond=AL, flag_write=11, alu NZCV=0100 -> nzcv=0100 at the next edge.
  - Cycle 2: cond=EQ, pc_src_in=1 -> cond_ex=1, pc_src=1.
  - Same cycle, cond=NE -> pc_src=0.
- Signed compare: nzcv=1001 (N=1, V=1):
  - cond=GE -> 1; LT -> 0; GT -> 1.
  - Set Z=1 (nzcv=1101) -> GT=0, LE=1.
- Suppressed instruction:
  - nzcv=0000, cond=EQ, flag_write=11, alu NZCV=1111, reg_write_in=1, mem_write_in=1 -> cond_ex=0, reg_write=0, mem_write=0, nzcv stays 0000.
  - cond=1111 -> cond_ex=0 regardless of flags.
- Partial update: nzcv=0011, cond=AL, flag_write=10, alu NZCV=1100 -> nzcv=1111 (C,V kept).
- Save/restore:
  - nzcv=1010, save_flags=1 -> shadow=1010.
  - Later nzcv=0101 with restore_flags=1 and a simultaneous AL flag_write=11 of 0000 -> nzcv=1010 (restore wins).
  - save_flags and restore_flags together with nzcv=0001, shadow=1000 -> nzcv=1000, shadow=0001.

Source files
------------

// File: rtl/cond_flag_unit_pkg.sv
// Shared ARM condition-code definitions: condition enum, NZCV flag indices and type.
// Used by cond_flag_unit and by any other stage that checks condition fields.
package arm_cond_pkg;

  localparam int NUM_FLAGS = 4;
  localparam int FLAG_N    = 3;
  localparam int FLAG_Z    = 2;
  localparam int FLAG_C    = 1;
  localparam int FLAG_V    = 0;

  typedef logic [NUM_FLAGS-1:0] nzcv_t;

  typedef enum logic [3:0] {
    EQ = 4'd0,  NE = 4'd1,  CS = 4'd2,  CC = 4'd3,
    MI = 4'd4,  PL = 4'd5,  VS = 4'd6,  VC = 4'd7,
    HI = 4'd8,  LS = 4'd9,  GE = 4'd10, LT = 4'd11,
    GT = 4'd12, LE = 4'd13, AL = 4'd14, NV = 4'd15
  } cond_e;

endpackage

// File: rtl/cond_flag_unit_if.sv
// Instruction/flag bus between decode/ALU and cond_flag_unit.
// Forwarding ports exist only when COND_FLAG_FORWARD_EN is defined.
interface cond_flag_if;
  logic       valid_in;
  logic [3:0] cond;
  logic [1:0] flag_write;
  logic       alu_n, alu_z, alu_c, alu_v;
  logic       pc_src_in, reg_write_in, mem_write_in;
  logic       save_flags, restore_flags;
`ifdef COND_FLAG_FORWARD_EN
  logic       fwd_valid;
  logic [3:0] fwd_nzcv;
`endif
  logic       cond_ex, pc_src, reg_write, mem_write;
  logic [3:0] nzcv, shadow_nzcv;

  modport master (
    output valid_in, cond, flag_write, alu_n, alu_z, alu_c, alu_v,
           pc_src_in, reg_write_in, mem_write_in, save_flags, restore_flags,
`ifdef COND_FLAG_FORWARD_EN
           fwd_valid, fwd_nzcv,
`endif
    input  cond_ex, pc_src, reg_write, mem_write, nzcv, shadow_nzcv
  );

  modport slave (
    input  valid_in, cond, flag_write, alu_n, alu_z, alu_c, alu_v,
           pc_src_in, reg_write_in, mem_write_in, save_flags, restore_flags,
`ifdef COND_FLAG_FORWARD_EN
           fwd_valid, fwd_nzcv,
`endif
    output cond_ex, pc_src, reg_write, mem_write, nzcv, shadow_nzcv
  );
endinterface

// File: rtl/cond_flag_unit_cond_check.sv
// Combinational ARM condition evaluator; NV (4'b1111) is reserved and never passes.
module cond_check
  import arm_cond_pkg::*;
(
  input  cond_e cond,
  input  nzcv_t nzcv,
  output logic  cond_true
);
  logic n, z, c, v;

  always_comb begin
    n = nzcv[FLAG_N];
    z = nzcv[FLAG_Z];
    c = nzcv[FLAG_C];
    v = nzcv[FLAG_V];
    cond_true = 1'b0;
    case (cond)
      EQ: cond_true = z;
      NE: cond_true = !z;
      CS: cond_true = c;
      CC: cond_true = !c;
      MI: cond_true = n;
      PL: cond_true = !n;
      VS: cond_true = v;
      VC: cond_true = !v;
      HI: cond_true = c & !z;
      LS: cond_true = !c | z;
      GE: cond_true = (n == v);
      LT: cond_true = (n != v);
      GT: cond_true = !z & (n == v);
      LE: cond_true = z | (n != v);
      AL: cond_true = 1'b1;
      NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end
endmodule

// File: rtl/cond_flag_unit.sv
// Conditional-execution stage: NZCV + shadow register, condition gating of write/branch controls.
// Define COND_FLAG_FORWARD_EN to evaluate conditions against forwarded fwd_nzcv when fwd_valid.
module cond_flag_unit
  import arm_cond_pkg::*;
#(
  parameter int    NUM_FLAGS   = 4,
  parameter nzcv_t RESET_FLAGS = 4'b0000
) (
  input logic         clk,
  input logic         rst_n,
  cond_flag_if.slave  bus
);
  logic [NUM_FLAGS-1:0] nzcv_q, nzcv_d;
  logic [NUM_FLAGS-1:0] shadow_q, shadow_d;
  nzcv_t eval_flags;
  logic  cond_true, cond_ex;

`ifdef COND_FLAG_FORWARD_EN
  assign eval_flags = bus.fwd_valid ? bus.fwd_nzcv : nzcv_q;
`else
  assign eval_flags = nzcv_q;
`endif

  cond_check u_cond_check (
    .cond      (cond_e'(bus.cond)),
    .nzcv      (eval_flags),
    .cond_true (cond_true)
  );

  assign cond_ex = bus.valid_in & cond_true;

  // Restore overrides the ALU write; save always captures the pre-edge NZCV,
  // so save+restore together swaps the two registers.
  always_comb begin
    nzcv_d   = nzcv_q;
    shadow_d = shadow_q;
    if (cond_ex && bus.flag_write[1]) begin
      nzcv_d[FLAG_N] = bus.alu_n;
      nzcv_d[FLAG_Z] = bus.alu_z;
    end
    if (cond_ex && bus.flag_write[0]) begin
      nzcv_d[FLAG_C] = bus.alu_c;
      nzcv_d[FLAG_V] = bus.alu_v;
    end
    if (bus.restore_flags) nzcv_d   = shadow_q;
    if (bus.save_flags)    shadow_d = nzcv_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzcv_q   <= RESET_FLAGS;
      shadow_q <= RESET_FLAGS;
    end else begin
      nzcv_q   <= nzcv_d;
      shadow_q <= shadow_d;
    end
  end

  assign bus.cond_ex     = cond_ex;
  assign bus.pc_src      = bus.pc_src_in    & cond_ex;
  assign bus.reg_write   = bus.reg_write_in & cond_ex;
  assign bus.mem_write   = bus.mem_write_in & cond_ex;
  assign bus.nzcv        = nzcv_q;
  assign bus.shadow_nzcv = shadow_q;
endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed self-checking bench for cond_flag_unit.
module tb_cond_flag_unit;
  import arm_cond_pkg::*;

  logic clk, rst_n;
  int checks = 0;
  int errors = 0;

  cond_flag_if bus ();

  cond_flag_unit #(.NUM_FLAGS(4), .RESET_FLAGS(4'b0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] fw,
                       input logic [3:0] alu, input logic pc, input logic rw,
                       input logic mw, input logic sv, input logic rs);
    bus.valid_in      = v;
    bus.cond          = c;
    bus.flag_write    = fw;
    {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = alu;
    bus.pc_src_in     = pc;
    bus.reg_write_in  = rw;
    bus.mem_write_in  = mw;
    bus.save_flags    = sv;
    bus.restore_flags = rs;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load NZCV through an unconditional full flag write.
  task automatic set_flags(input logic [3:0] f);
    drive(1'b1, AL, 2'b11, f, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic idle_cond(input logic [3:0] c);
    drive(1'b1, c, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
`ifdef COND_FLAG_FORWARD_EN
    bus.fwd_valid = 1'b0;
    bus.fwd_nzcv  = 4'b0000;
`endif
    // Reset with random inputs
    rst_n = 1'b0;
    drive(1'b1, EQ, 2'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom));
    tick(); tick();
    chk("rst_nzcv", bus.nzcv, 4'b0000);
    chk("rst_shadow", bus.shadow_nzcv, 4'b0000);
    chk("rst_eq_cond_ex", {3'b0, bus.cond_ex}, 4'b0000);
    bus.cond = AL; #1;
    chk("rst_al_cond_ex", {3'b0, bus.cond_ex}, 4'b0001);
    drive(1'b0, AL, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // CMP then BEQ / BNE
    set_flags(4'b0100);
    chk("cmp_nzcv", bus.nzcv, 4'b0100);
    drive(1'b1, EQ, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("beq_cond_ex", {3'b0, bus.cond_ex}, 4'b0001);
    chk("beq_pc_src", {3'b0, bus.pc_src}, 4'b0001);
    bus.cond = NE; #1;
    chk("bne_pc_src", {3'b0, bus.pc_src}, 4'b0000);
    drive(1'b0, AL, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("invalid_ctrl", {bus.cond_ex, bus.pc_src, bus.reg_write, bus.mem_write}, 4'b0000);

    // Signed compares
    set_flags(4'b1001);
    idle_cond(GE); chk("ge_1001", {3'b0, bus.cond_ex}, 4'b0001);
    idle_cond(LT); chk("lt_1001", {3'b0, bus.cond_ex}, 4'b0000);
    idle_cond(GT); chk("gt_1001", {3'b0, bus.cond_ex}, 4'b0001);
    idle_cond(LE); chk("le_1001", {3'b0, bus.cond_ex}, 4'b0000);
    idle_cond(MI); chk("mi_1001", {3'b0, bus.cond_ex}, 4'b0001);
    idle_cond(VC); chk("vc_1001", {3'b0, bus.cond_ex}, 4'b0000);
    set_flags(4'b1101);
    idle_cond(GT); chk("gt_1101", {3'b0, bus.cond_ex}, 4'b0000);
    idle_cond(LE); chk("le_1101", {3'b0, bus.cond_ex}, 4'b0001);

    // Unsigned compares with C=1, Z=0
    set_flags(4'b0010);
    idle_cond(HI); chk("hi_0010", {3'b0, bus.cond_ex}, 4'b0001);
    idle_cond(LS); chk("ls_0010", {3'b0, bus.cond_ex}, 4'b0000);
    idle_cond(CC); chk("cc_0010", {3'b0, bus.cond_ex}, 4'b0000);
    idle_cond(PL); chk("pl_0010", {3'b0, bus.cond_ex}, 4'b0001);
    idle_cond(VS); chk("vs_0010", {3'b0, bus.cond_ex}, 4'b0000);

    // Suppressed instruction leaves flags and controls untouched
    set_flags(4'b0000);
    drive(1'b1, EQ, 2'b11, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("supp_ctrl", {bus.cond_ex, bus.reg_write, bus.mem_write, 1'b0}, 4'b0000);
    tick();
    chk("supp_nzcv", bus.nzcv, 4'b0000);
    idle_cond(NV); chk("nv_0000", {3'b0, bus.cond_ex}, 4'b0000);
    set_flags(4'b1111);
    idle_cond(NV); chk("nv_1111", {3'b0, bus.cond_ex}, 4'b0000);
    idle_cond(LS); chk("ls_1111", {3'b0, bus.cond_ex}, 4'b0001);

    // Partial updates
    set_flags(4'b0011);
    drive(1'b1, AL, 2'b10, 4'b1100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("partial_nz", bus.nzcv, 4'b1111);
    drive(1'b1, AL, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("partial_cv", bus.nzcv, 4'b1100);

    // Save samples pre-edge NZCV even while NZCV is being written
    set_flags(4'b1010);
    drive(1'b1, AL, 2'b11, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("save_shadow", bus.shadow_nzcv, 4'b1010);
    chk("save_nzcv", bus.nzcv, 4'b0101);
    drive(1'b1, AL, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("restore_wins", bus.nzcv, 4'b1010);

    // Swap
    set_flags(4'b1000);
    drive(1'b1, AL, 2'b11, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("pre_swap_nzcv", bus.nzcv, 4'b0001);
    chk("pre_swap_shadow", bus.shadow_nzcv, 4'b1000);
    drive(1'b0, AL, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("swap_nzcv", bus.nzcv, 4'b1000);
    chk("swap_shadow", bus.shadow_nzcv, 4'b0001);

    // Asynchronous reset mid-operation discards the pending write
    drive(1'b1, AL, 2'b11, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_nzcv", bus.nzcv, 4'b0000);
    chk("async_rst_shadow", bus.shadow_nzcv, 4'b0000);
    tick();
    chk("rst_hold_nzcv", bus.nzcv, 4'b0000);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
